// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for uart_tx_arbiter.
// master drives requests and transmitter status; slave is the arbiter.
interface uart_tx_arbiter_if;
    logic       i_req0;
    logic [7:0] i_byte0;
    logic       i_last0;
    logic       o_ack0;
    logic       i_req1;
    logic [7:0] i_byte1;
    logic       i_last1;
    logic       o_ack1;
    logic       o_tx_dv;
    logic [7:0] o_tx_byte;
    logic       i_tx_active;
    logic       i_tx_done;
    logic       o_busy;
    logic       o_owner;

    modport master (
        output i_req0, i_byte0, i_last0, i_req1, i_byte1, i_last1,
               i_tx_active, i_tx_done,
        input  o_ack0, o_ack1, o_tx_dv, o_tx_byte, o_busy, o_owner
    );

    modport slave (
        input  i_req0, i_byte0, i_last0, i_req1, i_byte1, i_last1,
               i_tx_active, i_tx_done,
        output o_ack0, o_ack1, o_tx_dv, o_tx_byte, o_busy, o_owner
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin two-requester arbiter for one UART transmitter, with burst lock.
// Define UART_ARB_FIXED_PRIO_EN to give requester 0 fixed priority and lock preemption.
module uart_tx_arbiter #(
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned GAP_CYCLES = 0
) (
    input logic             i_clk,
    input logic             i_rst_n,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {ARB, SEND, WAIT, GAP} state_t;

    localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0] GAP_END   = GW'(GAP_LAST);
    localparam logic [3:0]    BURST_MAX = 4'(MAX_BURST);

`ifdef UART_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    state_t        state, state_nx;
    logic          lock, lock_nx;
    logic [3:0]    burst_cnt, burst_cnt_nx;
    logic          last_flag, last_flag_nx;
    logic          owner, owner_nx;
    logic [GW-1:0] gap_cnt, gap_cnt_nx;
    logic          busy, busy_nx;
    logic          ack0, ack0_nx;
    logic          ack1, ack1_nx;
    logic          tx_dv, tx_dv_nx;
    logic [7:0]    tx_byte, tx_byte_nx;

    logic grant;
    logic sel;
    logic lock_eff;
    logic own_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ARB;
            lock      <= 1'b0;
            burst_cnt <= '0;
            last_flag <= 1'b0;
            owner     <= 1'b1;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            tx_dv     <= 1'b0;
            tx_byte   <= '0;
        end else begin
            state     <= state_nx;
            lock      <= lock_nx;
            burst_cnt <= burst_cnt_nx;
            last_flag <= last_flag_nx;
            owner     <= owner_nx;
            gap_cnt   <= gap_cnt_nx;
            busy      <= busy_nx;
            ack0      <= ack0_nx;
            ack1      <= ack1_nx;
            tx_dv     <= tx_dv_nx;
            tx_byte   <= tx_byte_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        lock_nx      = lock;
        burst_cnt_nx = burst_cnt;
        last_flag_nx = last_flag;
        owner_nx     = owner;
        gap_cnt_nx   = gap_cnt;
        ack0_nx      = 1'b0;
        ack1_nx      = 1'b0;
        tx_dv_nx     = 1'b0;
        tx_byte_nx   = tx_byte;
        grant        = 1'b0;
        sel          = owner;
        lock_eff     = lock;
        own_req      = owner ? bus.i_req1 : bus.i_req0;

        case (state)
            ARB: begin
                if (!bus.i_tx_active) begin
                    if (FIXED_PRIO && lock && owner && bus.i_req0)
                        lock_eff = 1'b0;
                    if (lock_eff && own_req) begin
                        grant = 1'b1;
                        sel   = owner;
                    end else begin
                        // Lock (if any) is dropped and plain arbitration runs in the same cycle.
                        lock_eff = 1'b0;
                        if (bus.i_req0 && bus.i_req1) begin
                            grant = 1'b1;
                            sel   = FIXED_PRIO ? 1'b0 : ~owner;
                        end else if (bus.i_req0) begin
                            grant = 1'b1;
                            sel   = 1'b0;
                        end else if (bus.i_req1) begin
                            grant = 1'b1;
                            sel   = 1'b1;
                        end
                    end
                    lock_nx = lock_eff;
                    if (!lock_eff)
                        burst_cnt_nx = '0;
                    if (grant) begin
                        state_nx   = SEND;
                        tx_dv_nx   = 1'b1;
                        ack0_nx    = ~sel;
                        ack1_nx    = sel;
                        tx_byte_nx = sel ? bus.i_byte1 : bus.i_byte0;
                        owner_nx   = sel;
                    end
                end
            end
            SEND: begin
                last_flag_nx = owner ? bus.i_last1 : bus.i_last0;
                if (burst_cnt < BURST_MAX)
                    burst_cnt_nx = burst_cnt + 4'd1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.i_tx_done) begin
                    if (last_flag || (burst_cnt >= BURST_MAX)) begin
                        lock_nx      = 1'b0;
                        burst_cnt_nx = '0;
                    end else begin
                        lock_nx = 1'b1;
                    end
                    gap_cnt_nx = '0;
                    state_nx   = (GAP_CYCLES > 0) ? GAP : ARB;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_END)
                    state_nx = ARB;
                else
                    gap_cnt_nx = gap_cnt + GW'(1);
            end
            default: state_nx = ARB;
        endcase

        busy_nx = (state_nx != ARB);
    end

    assign bus.o_ack0    = ack0;
    assign bus.o_ack1    = ack1;
    assign bus.o_tx_dv   = tx_dv;
    assign bus.o_tx_byte = tx_byte;
    assign bus.o_busy    = busy;
    assign bus.o_owner   = owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level grant model checked every cycle,
// plus directed ordering/latency scenarios on a default and a gapped instance.
module tb_uart_tx_arbiter;

    localparam int unsigned MB     = 4;
    localparam int unsigned TX_LEN = 6;

`ifdef UART_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_nb;
    logic tx_busy = 1'b0;
    logic force_active = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if ifa ();
    uart_tx_arbiter_if ifb ();

    uart_tx_arbiter #(.MAX_BURST(MB), .GAP_CYCLES(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifa)
    );

    uart_tx_arbiter #(.MAX_BURST(1), .GAP_CYCLES(3)) u_gap (
        .i_clk(clk), .i_rst_n(rst_nb), .bus(ifb)
    );

    assign ifa.i_tx_active = tx_busy | force_active;

    int n_checks = 0;
    int n_fail   = 0;

    item_t      q0[$];
    item_t      q1[$];
    logic [7:0] sent[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Requesters: present queue head, pop it the cycle after its ack.
    initial begin : req0_proc
        bit ack_seen;
        ack_seen = 1'b0;
        ifa.i_req0 = 1'b0; ifa.i_byte0 = '0; ifa.i_last0 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack_seen && q0.size() > 0) void'(q0.pop_front());
            ack_seen = ifa.o_ack0;
            if (q0.size() > 0) begin
                ifa.i_req0 = 1'b1; ifa.i_byte0 = q0[0].b; ifa.i_last0 = q0[0].l;
            end else begin
                ifa.i_req0 = 1'b0;
            end
        end
    end

    initial begin : req1_proc
        bit ack_seen;
        ack_seen = 1'b0;
        ifa.i_req1 = 1'b0; ifa.i_byte1 = '0; ifa.i_last1 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack_seen && q1.size() > 0) void'(q1.pop_front());
            ack_seen = ifa.o_ack1;
            if (q1.size() > 0) begin
                ifa.i_req1 = 1'b1; ifa.i_byte1 = q1[0].b; ifa.i_last1 = q1[0].l;
            end else begin
                ifa.i_req1 = 1'b0;
            end
        end
    end

    // Transmitter: busy for TX_LEN cycles after each strobe, then one done pulse.
    initial begin : tx_proc
        int cnt;
        cnt = 0;
        ifa.i_tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            ifa.i_tx_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifa.i_tx_done = 1'b1;
                    tx_busy = 1'b0;
                end
            end
            if (ifa.o_tx_dv) begin
                tx_busy = 1'b1;
                cnt = TX_LEN;
            end
        end
    end

    // Grant model: a grant happens in the cycle after an idle, unstalled cycle with a request.
    initial begin : compare
        bit p_req0, p_req1, p_last0, p_last1, p_act, p_done;
        bit m_busy, m_lock, m_owner, w, exp_dv, own_req, preempt;
        logic [7:0] p_b0, p_b1, exp_byte;
        int unsigned m_cnt;
        {p_req0, p_req1, p_last0, p_last1, p_act, p_done} = '0;
        {m_busy, m_lock, w} = '0;
        m_owner = 1'b1; m_cnt = 0; p_b0 = '0; p_b1 = '0; exp_byte = '0;
        forever begin
            @(posedge clk); #4;
            if (!rst_n) begin
                m_busy = 1'b0; m_lock = 1'b0; m_owner = 1'b1; m_cnt = 0;
                {p_req0, p_req1, p_last0, p_last1, p_act, p_done} = '0;
                continue;
            end
            exp_dv = 1'b0;
            if (!m_busy && !p_act) begin
                own_req = m_owner ? p_req1 : p_req0;
                preempt = FIXED && m_lock && m_owner && p_req0;
                if (m_lock && (!own_req || preempt)) begin
                    m_lock = 1'b0; m_cnt = 0;
                end
                if (p_req0 || p_req1) begin
                    if (m_lock)                w = m_owner;
                    else if (p_req0 && p_req1) w = FIXED ? 1'b0 : !m_owner;
                    else                       w = p_req1;
                    exp_dv   = 1'b1;
                    exp_byte = w ? p_b1 : p_b0;
                    m_owner  = w;
                    if (m_cnt < MB) m_cnt++;
                    m_lock = !(w ? p_last1 : p_last0) && (m_cnt < MB);
                    if (!m_lock) m_cnt = 0;
                end
            end
            m_busy = exp_dv ? 1'b1 : (p_done ? 1'b0 : m_busy);
            check("tx_dv", ifa.o_tx_dv, exp_dv);
            check("ack0", ifa.o_ack0, exp_dv && !w);
            check("ack1", ifa.o_ack1, exp_dv && w);
            check("busy", ifa.o_busy, m_busy);
            if (exp_dv) begin
                check("tx_byte", ifa.o_tx_byte, exp_byte);
                check("owner", ifa.o_owner, w);
            end
            if (ifa.o_tx_dv) sent.push_back(ifa.o_tx_byte);
            p_req0 = ifa.i_req0;  p_req1 = ifa.i_req1;
            p_b0   = ifa.i_byte0; p_b1   = ifa.i_byte1;
            p_last0 = ifa.i_last0; p_last1 = ifa.i_last1;
            p_act  = ifa.i_tx_active; p_done = ifa.i_tx_done;
        end
    end

    task automatic cyc();
        @(posedge clk); #3;
    endtask

    task automatic wait_dv(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc();
            if (ifa.o_tx_dv) begin
                n = i;
                return;
            end
        end
        timeout("wait_dv");
    endtask

    task automatic wait_done();
        for (int i = 1; i <= 60; i++) begin
            cyc();
            if (ifa.i_tx_done) return;
        end
        timeout("wait_done");
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 800; i++) begin
            cyc();
            if (q0.size() == 0 && q1.size() == 0 && !ifa.i_req0 && !ifa.i_req1 &&
                !ifa.o_busy && !tx_busy) quiet++;
            else quiet = 0;
            if (quiet >= 3) return;
        end
        timeout("wait_idle");
    endtask

    task automatic reset_a();
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack0"}, ifa.o_ack0, 0);
        check({tag, "_ack1"}, ifa.o_ack1, 0);
        check({tag, "_dv"}, ifa.o_tx_dv, 0);
        check({tag, "_byte"}, ifa.o_tx_byte, 0);
        check({tag, "_busy"}, ifa.o_busy, 0);
        check({tag, "_owner"}, ifa.o_owner, 1);
    endtask

    task automatic check_order(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, sent.size(), exp.size());
        for (int i = 0; i < exp.size() && i < sent.size(); i++)
            check($sformatf("%s_%0d", name, i), sent[i], exp[i]);
    endtask

    task automatic push0(input logic [7:0] b, input logic l);
        q0.push_back(item_t'{b: b, l: l});
    endtask

    task automatic push1(input logic [7:0] b, input logic l);
        q1.push_back(item_t'{b: b, l: l});
    endtask

    task automatic script_a();
        int n;
        logic [7:0] exp_q[$];
        rst_n = 1'b0;
        repeat (3) cyc();
        check_reset_vals("rst");
        rst_n = 1'b1;
        cyc();

        sent.delete();
        push0(8'h41, 1'b1);
        wait_dv(n);
        check("single_latency", n, 2);
        check("single_byte", ifa.o_tx_byte, 8'h41);
        check("single_ack0", ifa.o_ack0, 1);
        check("single_ack1", ifa.o_ack1, 0);
        check("single_owner", ifa.o_owner, 0);
        cyc();
        check("single_dv_width", ifa.o_tx_dv, 0);
        check("single_ack_width", ifa.o_ack0, 0);
        wait_idle();
        check("single_busy", ifa.o_busy, 0);

        reset_a();
        sent.delete();
        push0(8'hA0, 1'b1); push0(8'hA0, 1'b1);
        push1(8'hB0, 1'b1); push1(8'hB0, 1'b1);
        wait_idle();
        if (FIXED) exp_q = '{8'hA0, 8'hA0, 8'hB0, 8'hB0};
        else       exp_q = '{8'hA0, 8'hB0, 8'hA0, 8'hB0};
        check_order("tie", exp_q);

        reset_a();
        sent.delete();
        for (int i = 1; i <= 6; i++) push0(8'(i), 1'b0);
        push1(8'hFF, 1'b1);
        wait_idle();
        if (FIXED) exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF};
        else       exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h05, 8'h06};
        check_order("burst", exp_q);

        reset_a();
        sent.delete();
        push0(8'h10, 1'b0); push0(8'h11, 1'b1);
        push1(8'h20, 1'b1);
        wait_idle();
        exp_q = '{8'h10, 8'h11, 8'h20};
        check_order("last", exp_q);

        reset_a();
        sent.delete();
        push0(8'h55, 1'b0); push0(8'h56, 1'b1);
        wait_dv(n);
        wait_done();
        wait_dv(n);
        check("b2b_latency", n, 2);
        check("b2b_byte", ifa.o_tx_byte, 8'h56);
        wait_idle();

        sent.delete();
        force_active = 1'b1;
        push1(8'hC3, 1'b1);
        repeat (6) cyc();
        check("stall_no_dv", sent.size(), 0);
        force_active = 1'b0;
        wait_dv(n);
        check("stall_release", n, 1);
        check("stall_byte", ifa.o_tx_byte, 8'hC3);
        wait_idle();

        sent.delete();
        push0(8'h77, 1'b1);
        wait_dv(n);
        cyc(); cyc();
        check("midwait_busy", ifa.o_busy, 1);
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        check_reset_vals("midrst");
        wait_done();
        repeat (3) cyc();
        check("stale_busy", ifa.o_busy, 0);
        check("stale_sent", sent.size(), 1);
        wait_idle();
    endtask

    task automatic bcyc();
        @(posedge clk); #1;
    endtask

    // Gapped, MAX_BURST=1 instance driven by hand.
    task automatic script_b();
        int n;
        logic a1;
        logic [7:0] second, third;
        second = FIXED ? 8'h5C : 8'h6B;
        third  = FIXED ? 8'h6B : 8'h5C;
        rst_nb = 1'b0;
        ifb.i_req0 = 1'b0; ifb.i_byte0 = '0; ifb.i_last0 = 1'b0;
        ifb.i_req1 = 1'b0; ifb.i_byte1 = '0; ifb.i_last1 = 1'b0;
        ifb.i_tx_active = 1'b0; ifb.i_tx_done = 1'b0;
        repeat (3) bcyc();
        rst_nb = 1'b1;
        bcyc();
        ifb.i_req0 = 1'b1; ifb.i_byte0 = 8'h5A; ifb.i_last0 = 1'b0;
        ifb.i_req1 = 1'b1; ifb.i_byte1 = 8'h6B; ifb.i_last1 = 1'b1;
        for (n = 1; n <= 20; n++) begin
            bcyc();
            if (ifb.o_tx_dv) break;
        end
        check("gap_first_latency", n, 1);
        check("gap_first_byte", ifb.o_tx_byte, 8'h5A);
        check("gap_first_owner", ifb.o_owner, 0);
        bcyc();
        ifb.i_byte0 = 8'h5C; ifb.i_last0 = 1'b1;
        ifb.i_tx_active = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bcyc(); bcyc();
            ifb.i_tx_active = 1'b0;
            ifb.i_tx_done = 1'b1;
            for (n = 1; n <= 20; n++) begin
                bcyc();
                ifb.i_tx_done = 1'b0;
                if (n == 3) check("gap_busy_in_gap", ifb.o_busy, 1);
                if (n == 4) check("gap_busy_in_arb", ifb.o_busy, 0);
                if (ifb.o_tx_dv) break;
            end
            check($sformatf("gap_latency_%0d", k), n, 5);
            check($sformatf("gap_byte_%0d", k), ifb.o_tx_byte, (k == 0) ? second : third);
            a1 = ifb.o_ack1;
            bcyc();
            if (a1) ifb.i_req1 = 1'b0;
            else    ifb.i_req0 = 1'b0;
            ifb.i_tx_active = 1'b1;
        end
        ifb.i_tx_active = 1'b0;
        bcyc();
    endtask

    initial begin
        rst_n  = 1'b0;
        rst_nb = 1'b0;
        fork
            script_a();
            script_b();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between two byte requesters, e.g. the RX echo path (req 0) and the status/debug path (req 1). Arbitration is round-robin. A requester can lock the transmitter for a burst of up to MAX_BURST bytes so that its multi-byte messages are not interleaved with the other requester's bytes. The block sits between the requesters and the transmitter's data-valid/active/done interface and issues exactly one transmit strobe per byte.

Parameters:
MAX_BURST, 4, maximum consecutive bytes one owner may send under lock (legal range 1..15).
GAP_CYCLES, 0, idle clock cycles inserted after each i_tx_done before the next arbitration (0 means no gap).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req0  in  1  requester 0 has a byte; held high until o_ack0
i_byte0  in  8  requester 0 byte; stable while i_req0=1
i_last0  in  1  byte is the last of requester 0's message; stable while i_req0=1
o_ack0  out  1  one-cycle strobe: i_byte0 accepted
i_req1, i_byte1, i_last1, o_ack1  as above, for requester 1
o_tx_dv  out  1  one-cycle strobe to transmitter: o_tx_byte is valid
o_tx_byte  out  8  byte to transmit; holds last value between strobes
i_tx_active  in  1  transmitter busy
i_tx_done  in  1  one-cycle strobe: transmitter finished a byte
o_busy  out  1  high from grant until release (states SEND, WAIT, GAP)
o_owner  out  1  current or most recent owner index

Behaviour:
- Clock and reset are fixed: one clock, i_clk; reset i_rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values: o_ack0=o_ack1=o_tx_dv=0, o_tx_byte=0, o_busy=0, o_owner=1 (so req 0 wins the first tie), lock=0, burst_cnt=0, state=ARB.
- States:
  - ARB: acts only when i_tx_active=0.
  - SEND: single cycle in which o_tx_dv and o_ack_owner are high.
  - WAIT: waits for i_tx_done.
  - GAP: counts GAP_CYCLES.
- ARB selection, evaluated in order:
  1. lock=1 and owner's req=1: serve the same owner.
  2. lock=1 and owner's req=0: clear lock, then apply rule 3 in the same cycle.
  3. No lock: if exactly one req is high, serve it. If both are high, serve the requester that is not o_owner.
- Serving latency: request sampled in ARB at edge N. SEND occupies cycle N+1: o_tx_dv=1, o_ack_x=1, o_tx_byte=i_byte_x, o_owner=x. Both strobes are exactly one cycle wide, and only one o_ack is ever high.
- Requester handshake: the requester may deassert req, or present its next byte, in the cycle after o_ack. That next byte is eligible at the next ARB.
- SEND moves to WAIT unconditionally. In the SEND cycle, last_flag is latched from i_last_x and burst_cnt is incremented (saturating at MAX_BURST).
- WAIT exit on i_tx_done=1:
  - lock = (last_flag==0) and (burst_cnt<MAX_BURST).
  - When lock becomes 0, burst_cnt is cleared.
  - Next state is GAP if GAP_CYCLES>0, otherwise ARB.
- GAP holds for exactly GAP_CYCLES cycles, then goes to ARB.
- Throughput: with GAP_CYCLES=0, a queued byte's o_tx_dv follows i_tx_done by 2 cycles (ARB sample, then SEND), provided i_tx_active is low.
- Boundary conditions:
  - i_tx_done outside WAIT is ignored, including a stale done after a reset.
  - i_tx_active high in ARB stalls arbitration, with no strobes.
  - A req dropped without an ack is legal. Nothing is sent and the lock is released per rule 2.
  - MAX_BURST=1 never locks (pure per-byte round-robin).
  - Reset mid-transfer returns to ARB with lock cleared. The transmitter's in-flight byte is not tracked, and the next grant waits for i_tx_active=0.

Optional Feature:
UART_ARB_FIXED_PRIO_EN:
- Defined: rule 3 tie-break always serves requester 0, and requester 0 may preempt a requester-1 lock. In ARB with lock held by 1 and i_req0=1, the lock is cleared and req 0 is served. Requester 1's lock is still honoured while i_req0=0.
- Undefined: round-robin as specified above.

Test Plan:
- Single byte: i_req0=1, i_byte0=8'h41, i_last0=1, transmitter idle -> o_tx_dv and o_ack0 high exactly 1 cycle at cycle+1, o_tx_byte=8'h41, o_owner=0; after i_tx_done, o_busy=0.
- Tie after reset: i_req0 and i_req1 high, both last=1, bytes 8'hA0 and 8'hB0, 2 bytes each -> transmitted order A0, B0, A0, B0.
- Burst lock, MAX_BURST=4: req 0 sends 6 bytes 8'h01..8'h06 with last=0 while req 1 holds 8'hFF -> order 01, 02, 03, 04, FF, 05, 06.
- Last ends lock: req 0 bytes 8'h10 (last=0) and 8'h11 (last=1), req 1 pending 8'h20 -> order 10, 11, 20.
- Gap and stall: GAP_CYCLES=3, i_tx_done pulse -> next o_tx_dv 5 cycles after done; with i_tx_active forced high in ARB, no o_tx_dv until it falls, then o_tx_dv 1 cycle later.
- Reset mid-WAIT: assert i_rst_n=0 for 2 cycles, then pulse i_tx_done -> outputs at reset values, no o_tx_dv, stale done ignored; with UART_ARB_FIXED_PRIO_EN defined, simultaneous requests always serve req 0 first.
